// File: rtl/agc_pkg.sv
// AGC shared definitions: FSM state encoding and default loop constants.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } agc_state_t;

  localparam int VPP_W_DEF      = 12;
  localparam int WIN_W_DEF      = 13;
  localparam int GAIN_W_DEF     = 6;
  localparam int GAIN_MIN_DEF   = 0;
  localparam int GAIN_MAX_DEF   = 63;
  localparam int GAIN_INIT_DEF  = 32;
  localparam int TGT_LO_DEF     = 2000;
  localparam int TGT_HI_DEF     = 3000;
  localparam int CLIP_LVL_DEF   = 4000;
  localparam int CLIP_STEP_DEF  = 4;
  localparam int WIN_FAST_DEF   = 1023;
  localparam int WIN_SLOW_DEF   = 4095;
  localparam int SETTLE_WIN_DEF = 2;
  localparam int HOLD_WIN_DEF   = 4;

endpackage

// File: rtl/agc_gain_sat.sv
// Saturating add of a signed step to the gain code, with a changed flag.
// Latency: combinational.
// Backpressure: none.
module agc_gain_sat #(
  parameter int GAIN_W   = 6,
  parameter int GAIN_MIN = 0,
  parameter int GAIN_MAX = 63,
  parameter int STEP_W   = 4
) (
  input  logic [GAIN_W-1:0]        gain_i,
  input  logic signed [STEP_W-1:0] step_i,
  output logic [GAIN_W-1:0]        gain_o,
  output logic                     changed_o
);

  // Two spare bits: one for the carry past GAIN_MAX, one for the sign below zero.
  localparam int EXT_W = GAIN_W + 2;
  localparam logic signed [EXT_W-1:0] MIN_X = EXT_W'(GAIN_MIN);
  localparam logic signed [EXT_W-1:0] MAX_X = EXT_W'(GAIN_MAX);

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] clamped;

  // Widen, add, clamp back into the legal code range.
  always_comb begin
    sum = $signed({2'b00, gain_i}) +
          $signed({{(EXT_W-STEP_W){step_i[STEP_W-1]}}, step_i});
    if (sum < MIN_X)      clamped = MIN_X;
    else if (sum > MAX_X) clamped = MAX_X;
    else                  clamped = sum;
    gain_o    = clamped[GAIN_W-1:0];
    changed_o = (gain_o != gain_i);
  end

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC: steps the PGA gain from detector peak-to-peak windows.
// Latency: 1 cycle from the found rising edge to updated outputs.
// Backpressure: none; found is a one-shot strobe and a held level is one event.
module agc_gain_ctrl
  import agc_pkg::*;
#(
  parameter int VPP_W      = VPP_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int GAIN_W     = GAIN_W_DEF,
  parameter int GAIN_MIN   = GAIN_MIN_DEF,
  parameter int GAIN_MAX   = GAIN_MAX_DEF,
  parameter int GAIN_INIT  = GAIN_INIT_DEF,
  parameter int TGT_LO     = TGT_LO_DEF,
  parameter int TGT_HI     = TGT_HI_DEF,
  parameter int CLIP_LVL   = CLIP_LVL_DEF,
  parameter int CLIP_STEP  = CLIP_STEP_DEF,
  parameter int WIN_FAST   = WIN_FAST_DEF,
  parameter int WIN_SLOW   = WIN_SLOW_DEF,
  parameter int SETTLE_WIN = SETTLE_WIN_DEF,
  parameter int HOLD_WIN   = HOLD_WIN_DEF
) (
  input  logic              clk_sample,
  input  logic              rst,
  input  logic              en,
  input  logic              found,
  input  logic [VPP_W-1:0]  Vpp,
  output logic [WIN_W-1:0]  ADcnt,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_upd,
  output logic              locked,
  output logic              clip,
  output logic [1:0]        state
);

  localparam int STEP_W = 4;
  localparam int SC_W   = $clog2(SETTLE_WIN + 1);
  localparam int HC_W   = $clog2(HOLD_WIN + 1);

  localparam logic [VPP_W-1:0]  LO_V     = VPP_W'(TGT_LO);
  localparam logic [VPP_W-1:0]  HI_V     = VPP_W'(TGT_HI);
  localparam logic [VPP_W-1:0]  CLIP_V   = VPP_W'(CLIP_LVL);
  localparam logic [WIN_W-1:0]  WF_V     = WIN_W'(WIN_FAST);
  localparam logic [WIN_W-1:0]  WS_V     = WIN_W'(WIN_SLOW);
  localparam logic [GAIN_W-1:0] GINIT_V  = GAIN_W'(GAIN_INIT);
  localparam logic [SC_W-1:0]   SETTLE_V = SC_W'(SETTLE_WIN);
  localparam logic [HC_W-1:0]   HOLD_V   = HC_W'(HOLD_WIN);
  localparam logic signed [STEP_W-1:0] STEP_CLIP = STEP_W'(-CLIP_STEP);
  localparam logic signed [STEP_W-1:0] STEP_DN   = STEP_W'(-1);
  localparam logic signed [STEP_W-1:0] STEP_UP   = STEP_W'(1);

  agc_state_t        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [WIN_W-1:0]  adcnt_q, adcnt_d;
  logic              upd_q, upd_d;
  logic              locked_q, locked_d;
  logic              clip_q, clip_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              found_q;

  logic                     evt;
  logic [HC_W-1:0]          hold_inc;
  logic signed [STEP_W-1:0] step;
  logic [GAIN_W-1:0]        sat_gain;
  logic                     sat_changed;

  // Pick the gain step this window's level would request.
  always_comb begin
    evt      = found & ~found_q;
    hold_inc = hold_q + 1'b1;
    step     = '0;
    if (Vpp >= CLIP_V)                  step = STEP_CLIP;
    else if (Vpp > HI_V)                step = STEP_DN;
    else if (Vpp < LO_V && hold_inc == HOLD_V) step = STEP_UP;
  end

  agc_gain_sat #(
    .GAIN_W   (GAIN_W),
    .GAIN_MIN (GAIN_MIN),
    .GAIN_MAX (GAIN_MAX),
    .STEP_W   (STEP_W)
  ) u_sat (
    .gain_i    (gain_q),
    .step_i    (step),
    .gain_o    (sat_gain),
    .changed_o (sat_changed)
  );

  // Next-state and output decisions; disable overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    adcnt_d  = adcnt_q;
    upd_d    = 1'b0;
    locked_d = locked_q;
    clip_d   = clip_q;
    settle_d = settle_q;
    hold_d   = hold_q;
    if (!en) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      clip_d   = 1'b0;
      settle_d = '0;
      hold_d   = '0;
      adcnt_d  = WF_V;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_V;
          adcnt_d  = WF_V;
        end
        ST_SETTLE: begin
          if (evt) begin
            settle_d = settle_q - 1'b1;
            if (settle_q == SC_W'(1)) state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (evt) begin
            if (Vpp >= CLIP_V) begin
              clip_d   = 1'b1;
              locked_d = 1'b0;
              hold_d   = '0;
            end else if (Vpp > HI_V) begin
              clip_d   = 1'b0;
              locked_d = 1'b0;
              hold_d   = '0;
            end else if (Vpp < LO_V) begin
              clip_d   = 1'b0;
              locked_d = 1'b0;
              hold_d   = (hold_inc == HOLD_V) ? '0 : hold_inc;
            end else begin
              clip_d   = 1'b0;
              locked_d = 1'b1;
              hold_d   = '0;
              adcnt_d  = WS_V;
            end
            // A real gain change restarts acquisition; a saturated step does not.
            if (sat_changed) begin
              gain_d   = sat_gain;
              upd_d    = 1'b1;
              adcnt_d  = WF_V;
              locked_d = 1'b0;
              state_d  = ST_SETTLE;
              settle_d = SETTLE_V;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sample) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gain_q   <= GINIT_V;
      adcnt_q  <= WF_V;
      upd_q    <= 1'b0;
      locked_q <= 1'b0;
      clip_q   <= 1'b0;
      settle_q <= '0;
      hold_q   <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      adcnt_q  <= adcnt_d;
      upd_q    <= upd_d;
      locked_q <= locked_d;
      clip_q   <= clip_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
      found_q  <= found;
    end
  end

  assign ADcnt    = adcnt_q;
  assign gain     = gain_q;
  assign gain_upd = upd_q;
  assign locked   = locked_q;
  assign clip     = clip_q;
  assign state    = state_q;

endmodule

// File: doc/agc_gain_ctrl.md
Name: agc_gain_ctrl

Overview:
Closed-loop AGC controller for the sample-domain peak-to-peak detector. It programs the detector's window length and consumes each window's peak-to-peak result and completion flag. From those it steps a PGA gain code with attack/release asymmetry, settle blanking and saturation. It sits between the detector and the analog PGA control pins, in the clk_sample domain.

Parameters:
VPP_W, 12, width of peak-to-peak input
WIN_W, 13, width of window-length output (matches detector counter)
GAIN_W, 6, gain code width
GAIN_MIN, 0, lowest gain code
GAIN_MAX, 63, highest gain code
GAIN_INIT, 32, gain code after reset
TGT_LO, 2000, lower edge of target band (counts)
TGT_HI, 3000, upper edge of target band
CLIP_LVL, 4000, clip threshold; fast attack at or above this
CLIP_STEP, 4, gain decrement on clip
WIN_FAST, 1023, window length while acquiring
WIN_SLOW, 4095, window length while locked
SETTLE_WIN, 2, windows discarded after any gain change or enable
HOLD_WIN, 4, consecutive low windows required before a release step

Ports:
clk_sample  in  1  sample clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  loop enable; level
found  in  1  detector window-complete flag, high one cycle per window
Vpp  in  VPP_W  detector peak-to-peak result, valid while found high
ADcnt  out  WIN_W  window length driven to detector
gain  out  GAIN_W  PGA gain code
gain_upd  out  1  one-cycle strobe, high the cycle after gain changes
locked  out  1  last evaluated window was in band
clip  out  1  last evaluated window was at or above CLIP_LVL
state  out  2  current FSM state, for debug

Behaviour:
- Reset values: gain=GAIN_INIT, ADcnt=WIN_FAST, gain_upd=0, locked=0, clip=0, state=IDLE. Internal counters are 0 and the found edge register is 0.
- Event definition: found sampled 1 with the previous sample 0. Vpp is captured on that same edge. A found held high for several cycles yields exactly one event.
- All outputs are registered. A decision made on the event edge is visible the following cycle (latency 1).
- States: IDLE=0, SETTLE=1, MEASURE=2.
- IDLE:
  - gain is held and events are ignored.
  - en=1 -> SETTLE with settle_cnt=SETTLE_WIN and ADcnt=WIN_FAST.
- SETTLE:
  - Each event decrements settle_cnt. Vpp is discarded and locked/clip are unchanged.
  - The event that brings settle_cnt to 0 -> MEASURE.
- MEASURE, on each event, first match wins:
  - Vpp>=CLIP_LVL: clip=1, locked=0, hold_cnt=0, gain=max(gain-CLIP_STEP, GAIN_MIN).
  - Vpp>TGT_HI: clip=0, locked=0, hold_cnt=0, gain=max(gain-1, GAIN_MIN).
  - Vpp<TGT_LO: clip=0, locked=0, hold_cnt+=1. When hold_cnt reaches HOLD_WIN: gain=min(gain+1, GAIN_MAX) and hold_cnt=0.
  - otherwise: locked=1, clip=0, hold_cnt=0, ADcnt=WIN_SLOW.
- Whenever gain actually changes:
  - gain_upd pulses for one cycle, ADcnt=WIN_FAST, locked=0.
  - -> SETTLE with settle_cnt=SETTLE_WIN.
- Saturation:
  - Gain arithmetic is done one bit wider, then clamped.
  - If the clamped gain equals the current gain: no gain_upd, stay in MEASURE, and hold_cnt still resets.
- ADcnt changes only on an event edge, because the detector counter has just cleared there. Mid-window changes are forbidden.
- en=0 in any state:
  - Next state is IDLE and the pending event is ignored.
  - gain is held; locked, clip, hold_cnt and settle_cnt clear; ADcnt=WIN_FAST.
- en=0 on the same edge as an event: en wins and no gain change occurs.
- rst takes priority over en and events. An asserted rst mid-SETTLE returns all values to reset values.
- Vpp==TGT_LO and Vpp==TGT_HI are both in band.

Decomposition:
- Package agc_pkg holds the state encoding (IDLE/SETTLE/MEASURE) and the default threshold/window constants.
- One sub-module, agc_gain_sat: a combinational saturating add/subtract of a signed step on the gain code. It returns the new gain and a changed flag.

Test Plan:
- Reset, en=1, events with Vpp=2500 -> after 2 settle events, the 3rd event sets locked=1 and ADcnt=4095; gain stays 32; no gain_upd.
- MEASURE, gain=32, event Vpp=4095 -> gain=28, clip=1, gain_upd for one cycle, ADcnt=1023, state=SETTLE.
- MEASURE, four consecutive events Vpp=500 -> gain unchanged for 3 events, gain=33 after the 4th. An in-band event at the 3rd -> hold_cnt resets and no step occurs.
- gain=1, event Vpp=4050 -> gain=0. Then gain=0 with Vpp=3500 -> gain stays 0, no gain_upd, state stays MEASURE.
- found held high 5 cycles with Vpp=3500 -> exactly one decrement.
- en dropped on the same cycle as an event with Vpp=4095 -> gain unchanged, state=IDLE. rst asserted mid-SETTLE -> gain=32, ADcnt=1023, state=IDLE.
